// File: rtl/instr_loader_pkg.sv
// instr_loader_pkg: shared states and constants for the program loader.
// The CHK state exists only when LOADER_CHECKSUM_EN is defined.
package instr_loader_pkg;

    localparam int MEM_ADDR_W = 8;
    localparam logic [3:0] MASK_ALL = 4'b1111;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        WRITE,
        DONE,
        ERR
`ifdef LOADER_CHECKSUM_EN
        , CHK
`endif
    } state_t;

    // A header word count of zero or beyond the memory size aborts the load.
    function automatic logic bad_count(input logic [31:0] n, input logic [31:0] max_words);
        return n == 32'd0 || n > max_words;
    endfunction

endpackage

// File: rtl/instr_loader_packer.sv
// instr_loader_packer: assembles accepted bytes into little-endian 32-bit words.
module instr_loader_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        accept,
    input  logic [7:0]  data,
    output logic        last,
    output logic [31:0] word,
    output logic [31:0] full
);

    logic [1:0] cnt;

    // Bytes enter at the top and shift down, so the first byte ends in [7:0].
    assign full = {data, word[31:8]};
    assign last = accept && cnt == 2'd3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            word <= '0;
        end else if (clr) begin
            cnt  <= '0;
            word <= '0;
        end else if (accept) begin
            cnt  <= cnt + 2'd1;
            word <= full;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// instr_loader: receives a length-prefixed byte stream and writes it to instruction memory.
// Define LOADER_CHECKSUM_EN to require a trailing sum-of-words checksum before DONE.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int MAX_WORDS      = 256,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  mem_we_re,
    output logic                  mem_request,
    output logic [3:0]            mem_mask,
    output logic [MEM_ADDR_W-1:0] mem_address,
    output logic [31:0]           mem_data,
    input  logic                  mem_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [8:0]            words_loaded,
    output logic                  core_hold
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t state, state_next;
    logic [8:0] cnt, n;
    logic [TW-1:0] tmr;
    logic [31:0] word, full;
    logic accept, last, restart, wr, in_chk;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t FINAL = CHK;
    logic [31:0] sum;
    assign in_chk = state == CHK;
`else
    localparam state_t FINAL = DONE;
    assign in_chk = 1'b0;
`endif

    instr_loader_packer u_packer (
        .clk    (clk),
        .rst    (rst),
        .clr    (restart),
        .accept (accept),
        .data   (rx_data),
        .last   (last),
        .word   (word),
        .full   (full)
    );

    assign wr           = state == WRITE;
    assign rx_ready     = state == HDR || state == DATA || in_chk;
    assign accept       = rx_valid && rx_ready;
    assign restart      = start && (state == IDLE || state == DONE || state == ERR);
    assign busy         = rx_ready || wr;
    assign done         = state == DONE;
    assign error        = state == ERR;
    assign core_hold    = !done;
    assign words_loaded = cnt;
    assign mem_request  = wr;
    assign mem_we_re    = wr;
    assign mem_mask     = wr ? MASK_ALL : '0;
    assign mem_address  = wr ? cnt[MEM_ADDR_W-1:0] : '0;
    assign mem_data     = wr ? word : '0;

    always_comb begin
        state_next = state;
        case (state)
            HDR:   if (last) state_next = bad_count(full, 32'(MAX_WORDS)) ? ERR : DATA;
            DATA:  if (last) state_next = WRITE;
            WRITE: begin
                if (mem_valid)
                    state_next = (cnt + 9'd1 == n) ? FINAL : DATA;
                else if (tmr == TW'(TIMEOUT_CYCLES - 1))
                    state_next = ERR;
            end
`ifdef LOADER_CHECKSUM_EN
            CHK:   if (last) state_next = (full == sum) ? DONE : ERR;
`endif
            default: if (restart) state_next = HDR;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            n     <= '0;
            tmr   <= '0;
        end else begin
            state <= state_next;
            // Counts consecutive WRITE cycles still waiting for the memory.
            tmr   <= (wr && !mem_valid) ? tmr + 1'b1 : '0;
            if (restart)
                cnt <= '0;
            else if (wr && mem_valid)
                cnt <= cnt + 9'd1;
            if (state == HDR && last)
                n <= full[8:0];
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            sum <= '0;
        else if (restart)
            sum <= '0;
        else if (wr && mem_valid)
            sum <= sum + word;
    end
`endif

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: table vectors, directed corner sequences and random loads
// checked against a word-list model of the expected memory writes.
module tb_instr_loader;

    logic        clk = 0, rst = 0, start = 0, rx_valid = 0, mem_valid = 0;
    logic [7:0]  rx_data = 0;
    logic        rx_ready, mem_we_re, mem_request, busy, done, error, core_hold;
    logic [3:0]  mem_mask;
    logic [7:0]  mem_address;
    logic [31:0] mem_data;
    logic [8:0]  words_loaded;

    int checks = 0, errors = 0, csum_off = 0;
    logic [31:0] words[256];
    int lats[256];
    logic req_seen = 0;

    typedef struct {
        logic [31:0] hdr;
        int          lat;
        logic        exp_err;
        logic [8:0]  exp_wl;
    } vec_t;
    vec_t vt[7];

    always #5 clk = ~clk;

    instr_loader dut (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .mem_we_re(mem_we_re), .mem_request(mem_request),
        .mem_mask(mem_mask), .mem_address(mem_address), .mem_data(mem_data),
        .mem_valid(mem_valid), .busy(busy), .done(done), .error(error),
        .words_loaded(words_loaded), .core_hold(core_hold)
    );

    always @(negedge clk) if (mem_request) req_seen = 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        repeat ($urandom_range(0, 1)) @(negedge clk);
        rx_data = b;
        rx_valid = 1;
        while (!rx_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t == 50) check("rx_ready_wait", rx_ready, 1);
        @(negedge clk);
        rx_valid = 0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic pulse_start;
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        check("start_clear", {busy, done, error, words_loaded, core_hold},
              {1'b1, 1'b0, 1'b0, 9'd0, 1'b1});
    endtask

    task automatic serve_write(input int lat, input int addr, input logic [31:0] data);
        for (int c = 0; c <= lat; c++) begin
            check("write_bus", {mem_request, mem_we_re, mem_mask, mem_address, mem_data, rx_ready, busy},
                  {1'b1, 1'b1, 4'hf, 8'(addr), data, 1'b0, 1'b1});
            if (c == lat) mem_valid = 1;
            @(negedge clk);
            mem_valid = 0;
        end
        check("write_release", {mem_request, words_loaded}, {1'b0, 9'(addr + 1)});
    endtask

    // Model: a valid header N yields writes of words[0..N-1] to addresses 0..N-1, then DONE.
    task automatic run_load(input logic [31:0] hdr);
        logic bad;
        logic [31:0] sum;
        bad = hdr == 0 || hdr > 256;
        sum = 0;
        req_seen = 0;
        pulse_start();
        send_word(hdr);
        if (bad) begin
            check("bad_hdr", {error, busy, done, core_hold, mem_request}, 5'b10010);
            check("no_request", req_seen, 0);
            return;
        end
        for (int i = 0; i < int'(hdr); i++) begin
            send_word(words[i]);
            serve_write(lats[i], i, words[i]);
            sum += words[i];
        end
`ifdef LOADER_CHECKSUM_EN
        check("chk_ready", rx_ready, 1);
        send_word(sum + 32'(csum_off));
        if (csum_off != 0) begin
            check("chk_bad", {error, done, core_hold}, 3'b101);
            return;
        end
`endif
        check("load_done", {done, error, busy, core_hold, words_loaded},
              {1'b1, 1'b0, 1'b0, 1'b0, hdr[8:0]});
    endtask

    initial begin
        vt[0] = '{32'd2,          0, 1'b0, 9'd2};
        vt[1] = '{32'd0,          0, 1'b1, 9'd0};
        vt[2] = '{32'd257,        0, 1'b1, 9'd0};
        vt[3] = '{32'd256,        0, 1'b0, 9'd256};
        vt[4] = '{32'd1,          5, 1'b0, 9'd1};
        vt[5] = '{32'd3,          2, 1'b0, 9'd3};
        vt[6] = '{32'h0001_0002,  0, 1'b1, 9'd0};

        @(negedge clk);
        check("reset_vals", {rx_ready, mem_we_re, mem_request, mem_mask, mem_address, mem_data,
                             busy, done, error, words_loaded, core_hold}, {59'd0, 1'b1});
        @(negedge clk) rst = 1;

        words[0] = 32'h0000_0013;
        words[1] = 32'h0010_0093;
        lats[0] = 0;
        lats[1] = 0;
        run_load(2);

        foreach (vt[k]) begin
            for (int i = 0; i < 256; i++) begin
                words[i] = $urandom;
                lats[i] = vt[k].lat;
            end
            run_load(vt[k].hdr);
            check("vec_err", error, vt[k].exp_err);
            check("vec_wl", words_loaded, vt[k].exp_wl);
        end

        // Start pulses mid-load must not restart the transfer.
        words[0] = 32'hcafe_0001;
        words[1] = 32'hcafe_0002;
        pulse_start();
        send_word(2);
        send_word(words[0]);
        serve_write(0, 0, words[0]);
        start = 1;
        @(negedge clk) start = 0;
        check("start_ignored", {words_loaded, busy}, {9'd1, 1'b1});
        send_word(words[1]);
        serve_write(0, 1, words[1]);
`ifdef LOADER_CHECKSUM_EN
        send_word(words[0] + words[1]);
`endif
        check("start_ignored_done", {done, words_loaded}, {1'b1, 9'd2});

        // Memory never answers: exactly TIMEOUT_CYCLES of WRITE, then ERR.
        begin
            int n = 0;
            pulse_start();
            send_word(1);
            send_word(32'hdead_beef);
            while (mem_request && n < 2000) begin
                @(negedge clk);
                n++;
            end
            check("timeout_len", n, 1024);
            check("timeout_state", {error, mem_request, core_hold, busy}, 4'b1010);
        end

        // Asynchronous reset in DATA after two bytes, then a clean reload.
        pulse_start();
        send_word(3);
        send_byte(8'h11);
        send_byte(8'h22);
        rst = 0;
        #1;
        check("async_reset", {rx_ready, mem_we_re, mem_request, mem_mask, mem_address, mem_data,
                              busy, done, error, words_loaded, core_hold}, {59'd0, 1'b1});
        @(negedge clk);
        check("reset_hold", {busy, core_hold, rx_ready}, 3'b010);
        rst = 1;
        words[0] = 32'h1234_5678;
        words[1] = 32'h9abc_def0;
        lats[0] = 1;
        lats[1] = 3;
        run_load(2);

`ifdef LOADER_CHECKSUM_EN
        words[0] = 32'h0000_0013;
        lats[0] = 0;
        csum_off = 1;
        run_load(1);
        csum_off = 0;
        run_load(1);
`endif

        for (int r = 0; r < 12; r++) begin
            logic [31:0] hdr;
            int sel = $urandom_range(0, 4);
            hdr = sel == 0 ? ($urandom_range(0, 1) ? 32'd0 : 32'd257 + $urandom_range(0, 1000))
                           : 32'($urandom_range(1, 6));
            for (int i = 0; i < 6; i++) begin
                words[i] = $urandom;
                lats[i] = $urandom_range(0, 4);
            end
            run_load(hdr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 256: maximum program length in words; it SHALL be no more than 256.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum number of cycles to wait for mem_valid.
REQ-003 SHALL have port clk  input  1  the single clock.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  pulse that begins a load.
REQ-006 SHALL have port rx_data  input  8  incoming program byte.
REQ-007 SHALL have port rx_valid  input  1  rx_data valid.
REQ-008 SHALL have port rx_ready  output  1  loader accepts a byte.
REQ-009 SHALL have port mem_we_re  output  1  instruction memory write/read select; 1 = write.
REQ-010 SHALL have port mem_request  output  1  instruction memory request.
REQ-011 SHALL have port mem_mask  output  4  byte-enable mask.
REQ-012 SHALL have port mem_address  output  8  instruction memory word address.
REQ-013 SHALL have port mem_data  output  32  instruction word to write.
REQ-014 SHALL have port mem_valid  input  1  instruction memory completion.
REQ-015 SHALL have ports busy, done, error  output  1 each  loader status flags.
REQ-016 SHALL have port words_loaded  output  9  count of words written.
REQ-017 SHALL have port core_hold  output  1  when high, keeps the core in reset.

Function
REQ-018 SHALL implement the states IDLE, HDR, DATA, WRITE, DONE and ERR, plus CHK when LOADER_CHECKSUM_EN is defined.
REQ-019 SHALL accept a byte only on a cycle where rx_valid and rx_ready are both high; rx_ready SHALL be high only in HDR, DATA and CHK.
REQ-020 SHALL go from IDLE, DONE or ERR to HDR on start, clearing done, error, words_loaded and the byte and word counters; start in any other state SHALL be ignored.
REQ-021 SHALL assemble every 4 accepted bytes into one word, little-endian, with the first byte in bits [7:0].
REQ-022 SHALL treat the first word as the word count N; N==0 or N>MAX_WORDS SHALL cause a transition to ERR on the next cycle, otherwise the next state is DATA.
REQ-023 SHALL enter WRITE on the cycle after the 4th byte of a data word; in WRITE it SHALL drive mem_request=1, mem_we_re=1, mem_mask=4'b1111, mem_address=word index and mem_data=the word.
REQ-024 SHALL hold all mem_* outputs stable in WRITE until mem_valid is sampled high; the first WRITE cycle counts as a sample.
REQ-025 SHALL deassert mem_request on the cycle after mem_valid, and at the same time increment the word index and words_loaded.
REQ-026 SHALL then go to DONE when the index equals N (or to CHK when LOADER_CHECKSUM_EN is defined), otherwise back to DATA.
REQ-027 SHALL go to ERR when TIMEOUT_CYCLES consecutive WRITE cycles pass without mem_valid; mem_request SHALL drop on entering ERR.
REQ-028 SHALL drive busy high in HDR, DATA, WRITE and CHK; done high only in DONE; error high only in ERR.
REQ-029 SHALL drive core_hold low only in DONE.
REQ-030 SHALL keep mem_address within [7:0], with the word index never exceeding N-1, so no wrap-around occurs.

Reset
REQ-031 SHALL, while rst is low, immediately force state IDLE, rx_ready=0, mem_request=0, mem_we_re=0, mem_mask=0, mem_address=0, mem_data=0, busy=0, done=0, error=0, words_loaded=0 and core_hold=1, including in the middle of a write.

Configuration
REQ-032 When LOADER_CHECKSUM_EN is defined, SHALL accept one extra 4-byte word in CHK after the last data word; it SHALL go to DONE when that word equals the mod-2^32 sum of all data words, otherwise to ERR.
REQ-033 When LOADER_CHECKSUM_EN is undefined, SHALL have no CHK state and no checksum logic, and SHALL go from the final write directly to DONE.

Structure
REQ-034 SHALL take the state enum, MEM_ADDR_W=8 and MASK_ALL=4'b1111 from the shared package instr_loader_pkg.
REQ-035 SHALL do byte-to-word assembly and the byte counter in sub-module instr_loader_packer.

Verification
REQ-036 Test: start, header 02 00 00 00, bytes 13 00 00 00 93 00 10 00, with mem_valid in the first WRITE cycle -> writes to address 0 with data 0x00000013 and to address 1 with data 0x00100093, then done=1, words_loaded=2, core_hold=0.
REQ-037 Test: header 00 00 00 00 -> error=1 on the cycle after the 4th byte; mem_request never goes high.
REQ-038 Test: mem_valid delayed 5 cycles -> mem_request is held for 6 cycles with address and data stable; rx_ready=0 throughout.
REQ-039 Test: mem_valid held low -> ERR after 1024 WRITE cycles, with mem_request=0 and core_hold=1.
REQ-040 Test: rst pulled low in DATA after 2 bytes -> all outputs take their reset values at once; after reset and a new start, a fresh load completes correctly.
REQ-041 Test (LOADER_CHECKSUM_EN defined): N=1, word 0x00000013, checksum 0x00000014 -> error=1; checksum 0x00000013 -> done=1.
